// File: rtl/jtframe_input_merge.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_input_merge
// Purpose  : PS/2 + MiSTer joystick merge into registered active-low game
//            inputs, with pause toggle, coin stretcher and autofire
// Revision : 1.0
// ============================================================================
module jtframe_input_merge #(
    parameter int          NPLAYERS     = 2,
    parameter int          NBUTTONS     = 1,
    parameter logic [15:0] COIN_W       = 16'd4096,
    parameter int unsigned AUTOFIRE_DIV = 32'd2000000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [10:0]                      ps2_key,
    input  logic [16*NPLAYERS-1:0]           joy,
    input  logic                             soft_rst,
    input  logic                             autofire_en,
    output logic [(4+NBUTTONS)*NPLAYERS-1:0] game_joy,
    output logic [NPLAYERS-1:0]              game_start,
    output logic                             game_coin,
    output logic                             pause
);
    localparam int c_JW   = 4 + NBUTTONS;
    localparam int c_AF_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam logic [c_AF_W-1:0] c_AF_LAST = c_AF_W'(AUTOFIRE_DIV - 1);

    localparam logic [7:0] c_KEY_UP     = 8'h75;
    localparam logic [7:0] c_KEY_DOWN   = 8'h72;
    localparam logic [7:0] c_KEY_LEFT   = 8'h6B;
    localparam logic [7:0] c_KEY_RIGHT  = 8'h74;
    localparam logic [7:0] c_KEY_BTN0   = 8'h14;
    localparam logic [7:0] c_KEY_BTN1   = 8'h11;
    localparam logic [7:0] c_KEY_BTN2   = 8'h29;
    localparam logic [7:0] c_KEY_BTN3   = 8'h12;
    localparam logic [7:0] c_KEY_START0 = 8'h05;
    localparam logic [7:0] c_KEY_START1 = 8'h06;
    localparam logic [7:0] c_KEY_COIN   = 8'h04;
    localparam logic [7:0] c_KEY_PAUSE  = 8'h0C;

    logic                    r_armed;
    logic                    r_kb_ref;
    logic [3:0]              r_kb_dir;      // {up, down, left, right}
    logic [3:0]              r_kb_btn;
    logic [3:0]              r_kb_start;    // sized for 4 players; only [1:0] have keys
    logic                    r_kb_coin;
    logic                    r_kb_pause;
    logic [c_AF_W-1:0]       r_af_cnt;
    logic                    r_af_phase;
    logic [15:0]             r_coin_cnt;
    logic                    r_coin_prev;
    logic                    r_pause_prev;
    logic                    r_pause;
    logic [c_JW*NPLAYERS-1:0] r_game_joy;
    logic [NPLAYERS-1:0]     r_game_start;

    logic [c_JW*NPLAYERS-1:0] w_joy_next;
    logic [NPLAYERS-1:0]     w_start_next;
    logic [NPLAYERS-1:0]     w_coin_p;
    logic [NPLAYERS-1:0]     w_pause_p;
    logic                    w_coin;
    logic                    w_pause;
    logic                    w_coin_rise;
    logic                    w_pause_rise;
    logic                    w_unused;

    // First cycle out of reset only captures the toggle bit so a stale level is not decoded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed    <= 1'b0;
            r_kb_ref   <= 1'b0;
            r_kb_dir   <= 4'b0;
            r_kb_btn   <= 4'b0;
            r_kb_start <= 4'b0;
            r_kb_coin  <= 1'b0;
            r_kb_pause <= 1'b0;
        end else if (!r_armed) begin
            r_armed  <= 1'b1;
            r_kb_ref <= ps2_key[10];
        end else if (ps2_key[10] != r_kb_ref) begin
            r_kb_ref <= ps2_key[10];
            case (ps2_key[7:0])
                c_KEY_UP:     r_kb_dir[3]   <= ps2_key[9];
                c_KEY_DOWN:   r_kb_dir[2]   <= ps2_key[9];
                c_KEY_LEFT:   r_kb_dir[1]   <= ps2_key[9];
                c_KEY_RIGHT:  r_kb_dir[0]   <= ps2_key[9];
                c_KEY_BTN0:   r_kb_btn[0]   <= ps2_key[9];
                c_KEY_BTN1:   r_kb_btn[1]   <= ps2_key[9];
                c_KEY_BTN2:   r_kb_btn[2]   <= ps2_key[9];
                c_KEY_BTN3:   r_kb_btn[3]   <= ps2_key[9];
                c_KEY_START0: r_kb_start[0] <= ps2_key[9];
                c_KEY_START1: r_kb_start[1] <= ps2_key[9];
                c_KEY_COIN:   r_kb_coin     <= ps2_key[9];
                c_KEY_PAUSE:  r_kb_pause    <= ps2_key[9];
                default: ;
            endcase
        end
    end

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
        logic [3:0]          w_kb_dir;
        logic [NBUTTONS-1:0] w_kb_btn;
        logic [3:0]          w_raw_dir;
        logic [NBUTTONS-1:0] w_raw_btn;
        logic [NBUTTONS-1:0] w_af_mask;

        assign w_kb_dir  = (p == 0) ? r_kb_dir : 4'b0;
        assign w_kb_btn  = (p == 0) ? r_kb_btn[NBUTTONS-1:0] : {NBUTTONS{1'b0}};
        assign w_raw_dir = joy[16*p +: 4] | w_kb_dir;
        assign w_raw_btn = joy[16*p+4 +: NBUTTONS] | w_kb_btn;
        assign w_af_mask = autofire_en ? {NBUTTONS{r_af_phase}} : {NBUTTONS{1'b1}};

        assign w_joy_next[c_JW*p +: c_JW] = ~{w_raw_btn & w_af_mask, w_raw_dir};
        assign w_start_next[p] = ~(joy[16*p+8] | r_kb_start[p]);
        assign w_coin_p[p]     = joy[16*p+9];
        assign w_pause_p[p]    = joy[16*p+10];
    end

    assign w_coin       = (|w_coin_p) | r_kb_coin;
    assign w_pause      = (|w_pause_p) | r_kb_pause;
    // Edges are only honoured once armed, so levels held through reset release are ignored
    assign w_coin_rise  = r_armed & w_coin & ~r_coin_prev;
    assign w_pause_rise = r_armed & w_pause & ~r_pause_prev;
    assign w_unused     = ^{ps2_key[8], joy, r_kb_btn, r_kb_start};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_game_joy   <= '1;
            r_game_start <= '1;
        end else begin
            r_game_joy   <= w_joy_next;
            r_game_start <= w_start_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b0;
        end else if (r_af_cnt == c_AF_LAST) begin
            r_af_cnt   <= '0;
            r_af_phase <= ~r_af_phase;
        end else begin
            r_af_cnt   <= r_af_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coin_cnt  <= 16'd0;
            r_coin_prev <= 1'b0;
        end else begin
            r_coin_prev <= w_coin;
            if (r_coin_cnt == 16'd0) begin
                if (w_coin_rise) r_coin_cnt <= COIN_W;
            end else begin
                r_coin_cnt <= r_coin_cnt - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pause      <= 1'b0;
            r_pause_prev <= 1'b0;
        end else begin
            r_pause_prev <= w_pause;
            if (soft_rst)          r_pause <= 1'b0;
            else if (w_pause_rise) r_pause <= ~r_pause;
        end
    end

    assign game_joy   = r_game_joy;
    assign game_start = r_game_start;
    assign game_coin  = (r_coin_cnt == 16'd0);
    assign pause      = r_pause;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_input_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_input_merge
// Purpose  : scoreboard bench for jtframe_input_merge (2P/4B and 1P/2B builds)
// Revision : 1.0
// ============================================================================
module tb_jtframe_input_merge;
    localparam int c_SEL_JOY    = 0;
    localparam int c_SEL_START  = 1;
    localparam int c_SEL_COIN   = 2;
    localparam int c_SEL_PAUSE  = 3;
    localparam int c_SEL_JOY1   = 4;
    localparam int c_SEL_START1 = 5;
    localparam int c_SEL_COIN1  = 6;
    localparam int c_SEL_PAUSE1 = 7;

    typedef struct {
        int          cyc;
        string       nm;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        r_rst_n;
    logic [10:0] r_ps2;
    logic [31:0] r_joy;
    logic [15:0] r_joy1;
    logic        r_soft;
    logic        r_af;
    logic        r_tog;

    logic [15:0] w_game_joy;
    logic [1:0]  w_game_start;
    logic        w_game_coin;
    logic        w_pause;
    logic [5:0]  w_game_joy1;
    logic [0:0]  w_game_start1;
    logic        w_game_coin1;
    logic        w_pause1;

    int   cyc = 0;
    int   rel_cyc = 0;
    int   k0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];

    jtframe_input_merge #(
        .NPLAYERS(2), .NBUTTONS(4), .COIN_W(16'd8), .AUTOFIRE_DIV(4)
    ) dut (
        .clk(clk), .rst_n(r_rst_n), .ps2_key(r_ps2), .joy(r_joy),
        .soft_rst(r_soft), .autofire_en(r_af), .game_joy(w_game_joy),
        .game_start(w_game_start), .game_coin(w_game_coin), .pause(w_pause)
    );

    jtframe_input_merge #(
        .NPLAYERS(1), .NBUTTONS(2), .COIN_W(16'd8), .AUTOFIRE_DIV(4)
    ) dut_small (
        .clk(clk), .rst_n(r_rst_n), .ps2_key(r_ps2), .joy(r_joy1),
        .soft_rst(r_soft), .autofire_en(r_af), .game_joy(w_game_joy1),
        .game_start(w_game_start1), .game_coin(w_game_coin1), .pause(w_pause1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            c_SEL_JOY:    actual = {16'b0, w_game_joy};
            c_SEL_START:  actual = {30'b0, w_game_start};
            c_SEL_COIN:   actual = {31'b0, w_game_coin};
            c_SEL_PAUSE:  actual = {31'b0, w_pause};
            c_SEL_JOY1:   actual = {26'b0, w_game_joy1};
            c_SEL_START1: actual = {31'b0, w_game_start1};
            c_SEL_COIN1:  actual = {31'b0, w_game_coin1};
            default:      actual = {31'b0, w_pause1};
        endcase
    endfunction

    // Monitor: compares every scoreboard entry due in the current cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                n_checks++;
                if (sb[i].cyc < cyc || actual(sb[i].sel) !== sb[i].val) begin
                    n_err++;
                    $display("FAIL %s: cyc=%0d got=%h expected=%h", sb[i].nm, cyc,
                             actual(sb[i].sel), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic exp_push(input string nm, input int sel, input logic [31:0] v, input int d);
        exp_t e;
        e.cyc = cyc + d;
        e.nm  = nm;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [7:0] code, input logic pressed);
        r_tog = ~r_tog;
        r_ps2 = {r_tog, pressed, 1'b0, code};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        r_rst_n = 1'b0; r_ps2 = '0; r_joy = '0; r_joy1 = '0;
        r_soft = 1'b0; r_af = 1'b0; r_tog = 1'b0;
        tick(); tick();
        exp_push("rst_joy",    c_SEL_JOY,    32'hFFFF, 0);
        exp_push("rst_start",  c_SEL_START,  32'h3,    0);
        exp_push("rst_coin",   c_SEL_COIN,   32'h1,    0);
        exp_push("rst_pause",  c_SEL_PAUSE,  32'h0,    0);
        exp_push("rst_joy1",   c_SEL_JOY1,   32'h3F,   0);
        exp_push("rst_start1", c_SEL_START1, 32'h1,    0);
        exp_push("rst_coin1",  c_SEL_COIN1,  32'h1,    0);
        tick();
        r_rst_n = 1'b1;
        rel_cyc = cyc;
        repeat (5) tick();

        // joystick direct path, 1 clk
        r_joy[3] = 1'b1;
        exp_push("joy_up",       c_SEL_JOY,   32'hFFF7, 1);
        exp_push("joy_up_start", c_SEL_START, 32'h3,    1);
        exp_push("joy_up_coin",  c_SEL_COIN,  32'h1,    1);
        exp_push("joy_up_pause", c_SEL_PAUSE, 32'h0,    1);
        tick();
        r_joy = '0; r_joy[8] = 1'b1; r_joy[16+7] = 1'b1;
        exp_push("joy_p1_btn3",  c_SEL_JOY,   32'h7FFF, 1);
        exp_push("joy_start0",   c_SEL_START, 32'h2,    1);
        tick();
        r_joy = '0;
        exp_push("joy_idle",     c_SEL_JOY,   32'hFFFF, 1);
        repeat (2) tick();

        // keyboard, 2 clk
        key(8'h6B, 1'b1);
        exp_push("kb_left_lat", c_SEL_JOY,  32'hFFFF, 1);
        exp_push("kb_left",     c_SEL_JOY,  32'hFFFD, 2);
        exp_push("kb_left_s",   c_SEL_JOY1, 32'h3D,   2);
        repeat (3) tick();
        key(8'h6B, 1'b0);
        exp_push("kb_left_hold", c_SEL_JOY, 32'hFFFD, 1);
        exp_push("kb_left_rel",  c_SEL_JOY, 32'hFFFF, 2);
        repeat (3) tick();
        key(8'h33, 1'b1);
        exp_push("kb_unlisted",    c_SEL_JOY,   32'hFFFF, 2);
        exp_push("kb_unlisted_st", c_SEL_START, 32'h3,    2);
        repeat (3) tick();

        // back-to-back events
        key(8'h72, 1'b1);
        exp_push("b2b_down", c_SEL_JOY, 32'hFFFB, 2);
        tick();
        key(8'h74, 1'b1);
        exp_push("b2b_both", c_SEL_JOY, 32'hFFFA, 2);
        tick();
        key(8'h72, 1'b0);
        tick();
        key(8'h74, 1'b0);
        exp_push("b2b_rel", c_SEL_JOY, 32'hFFFF, 2);
        repeat (3) tick();

        // key map limits per build
        key(8'h06, 1'b1);
        exp_push("kb_start1",     c_SEL_START,  32'h1,  2);
        exp_push("kb_start1_s",   c_SEL_START1, 32'h1,  2);
        exp_push("kb_start1_sj",  c_SEL_JOY1,   32'h3F, 2);
        repeat (3) tick();
        key(8'h06, 1'b0);
        repeat (3) tick();
        key(8'h29, 1'b1);
        exp_push("kb_btn2",   c_SEL_JOY,  32'hFFBF, 2);
        exp_push("kb_btn2_s", c_SEL_JOY1, 32'h3F,   2);
        repeat (3) tick();
        key(8'h29, 1'b0);
        repeat (3) tick();
        key(8'h11, 1'b1);
        exp_push("kb_btn1",   c_SEL_JOY,  32'hFFDF, 2);
        exp_push("kb_btn1_s", c_SEL_JOY1, 32'h1F,   2);
        repeat (3) tick();
        key(8'h11, 1'b0);
        repeat (3) tick();
        key(8'h05, 1'b1);
        exp_push("kb_start0",   c_SEL_START,  32'h2, 2);
        exp_push("kb_start0_s", c_SEL_START1, 32'h0, 2);
        repeat (3) tick();
        key(8'h05, 1'b0);
        repeat (3) tick();

        // coin stretcher: pulses at +0, +3 (ignored) and +10
        k0 = cyc;
        for (int d = 0; d <= 20; d++)
            exp_push("coin", c_SEL_COIN,
                     ((d >= 1 && d <= 8) || (d >= 11 && d <= 18)) ? 32'h0 : 32'h1, d);
        for (int d = 0; d <= 20; d++) begin
            r_joy[9] = (d == 0 || d == 3 || d == 10);
            tick();
        end
        repeat (2) tick();

        // pause via keyboard
        key(8'h0C, 1'b1);
        exp_push("pause_lat",  c_SEL_PAUSE,  32'h0, 1);
        exp_push("pause_on",   c_SEL_PAUSE,  32'h1, 2);
        exp_push("pause_on_s", c_SEL_PAUSE1, 32'h1, 2);
        repeat (2) tick();
        key(8'h0C, 1'b0);
        exp_push("pause_hold", c_SEL_PAUSE, 32'h1, 2);
        repeat (2) tick();
        key(8'h0C, 1'b1);
        exp_push("pause_off",  c_SEL_PAUSE, 32'h0, 2);
        repeat (2) tick();
        key(8'h0C, 1'b0);
        repeat (3) tick();

        // soft reset vs pause toggle
        r_joy[26] = 1'b1; r_soft = 1'b1;
        exp_push("pause_softrst_prio", c_SEL_PAUSE, 32'h0, 1);
        tick();
        r_joy[26] = 1'b0; r_soft = 1'b0;
        exp_push("pause_softrst_after", c_SEL_PAUSE, 32'h0, 1);
        repeat (2) tick();
        r_joy[26] = 1'b1;
        exp_push("pause_joy_on", c_SEL_PAUSE, 32'h1, 1);
        tick();
        r_joy[26] = 1'b0;
        repeat (2) tick();
        r_soft = 1'b1;
        exp_push("pause_softrst_clr", c_SEL_PAUSE, 32'h0, 1);
        exp_push("softrst_coin",      c_SEL_COIN,  32'h1, 1);
        tick();
        r_soft = 1'b0;
        tick();

        // autofire: phase flips every 4 clks counted from reset release
        r_af = 1'b1; r_joy[4] = 1'b1; r_joy[3] = 1'b1;
        k0 = cyc;
        for (int m = k0 + 1; m <= k0 + 16; m++)
            exp_push("autofire", c_SEL_JOY,
                     ((((m - 1 - rel_cyc) / 4) % 2) == 1) ? 32'hFFE7 : 32'hFFF7, m - k0);
        repeat (16) tick();
        r_af = 1'b0;
        for (int d = 1; d <= 8; d++)
            exp_push("autofire_off", c_SEL_JOY, 32'hFFE7, d);
        repeat (8) tick();
        r_joy = '0;
        repeat (2) tick();

        // asynchronous reset in the middle of a coin pulse
        r_joy[26] = 1'b1; r_joy[9] = 1'b1; r_joy[3] = 1'b1;
        exp_push("pre_rst_coin",  c_SEL_COIN,  32'h0,    1);
        exp_push("pre_rst_pause", c_SEL_PAUSE, 32'h1,    1);
        exp_push("pre_rst_joy",   c_SEL_JOY,   32'hFFF7, 1);
        tick();
        r_joy[26] = 1'b0; r_joy[9] = 1'b0;
        repeat (2) tick();
        r_rst_n = 1'b0;
        exp_push("arst_coin",  c_SEL_COIN,  32'h1,    0);
        exp_push("arst_pause", c_SEL_PAUSE, 32'h0,    0);
        exp_push("arst_joy",   c_SEL_JOY,   32'hFFFF, 0);
        exp_push("arst_start", c_SEL_START, 32'h3,    0);
        #1;
        n_checks++;
        if (w_game_coin !== 1'b1) begin
            n_err++;
            $display("FAIL arst_now_coin: got=%b expected=1", w_game_coin);
        end
        n_checks++;
        if (w_pause !== 1'b0) begin
            n_err++;
            $display("FAIL arst_now_pause: got=%b expected=0", w_pause);
        end
        n_checks++;
        if (w_game_joy !== 16'hFFFF) begin
            n_err++;
            $display("FAIL arst_now_joy: got=%h expected=ffff", w_game_joy);
        end
        n_checks++;
        if (w_game_start !== 2'b11) begin
            n_err++;
            $display("FAIL arst_now_start: got=%b expected=11", w_game_start);
        end
        tick();
        r_rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        #1;
        for (int i = 0; i < sb.size(); i++) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: got=unchecked expected=%h", sb[i].nm, sb[i].val);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
